// File: rtl/cnn_core_mac_pkg.sv
// Shared helpers for the CNN core MAC pipeline: product width and
// saturating signed add used by the accumulator.
package cnn_core_mac_pkg;

  // Working width for the saturation helpers; accumulators must be narrower.
  localparam int SAT_W = 128;

  function automatic int prod_w(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  // Largest signed value representable in w bits, held in SAT_W bits.
  function automatic logic signed [SAT_W-1:0] acc_max(input int w);
    logic signed [SAT_W-1:0] m;
    m = '1;
    m = m >> (SAT_W - w + 1);
    return m;
  endfunction

  // Most negative signed value representable in w bits, held in SAT_W bits.
  function automatic logic signed [SAT_W-1:0] acc_min(input int w);
    return ~acc_max(w);
  endfunction

  // a and b must already lie in the signed w-bit range; returns {ovf, clamped sum}.
  function automatic logic [SAT_W:0] sat_add(input logic signed [SAT_W-1:0] a,
                                             input logic signed [SAT_W-1:0] b,
                                             input int w);
    logic signed [SAT_W-1:0] s;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    logic                    o;
    s  = a + b;
    hi = acc_max(w);
    lo = acc_min(w);
    o  = 1'b0;
    if (s > hi) begin
      s = hi;
      o = 1'b1;
    end else if (s < lo) begin
      s = lo;
      o = 1'b1;
    end
    return {o, s};
  endfunction

endpackage

// File: rtl/cnn_core_mac_pipe_mul_pipe.sv
// Signed multiplier followed by NUM_STAGE product registers carrying
// valid/last sideband; the whole pipe advances only when ce is high.
module cnn_core_mac_mul_pipe
  import cnn_core_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 6,
  parameter int NUM_STAGE  = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  ce,
  input  logic                                  in_valid,
  input  logic                                  in_last,
  input  logic signed [DIN0_WIDTH-1:0]          din0,
  input  logic signed [DIN1_WIDTH-1:0]          din1,
  output logic                                  p_valid,
  output logic                                  p_last,
  output logic signed [DIN0_WIDTH+DIN1_WIDTH-1:0] product
);

  localparam int PW = prod_w(DIN0_WIDTH, DIN1_WIDTH);

  logic signed [PW-1:0]  a_ext;
  logic signed [PW-1:0]  b_ext;
  logic signed [PW-1:0]  mult;
  logic [NUM_STAGE-1:0]  vld;
  logic [NUM_STAGE-1:0]  lst;
  logic signed [PW-1:0]  prd [NUM_STAGE];

  // Full-precision signed product; PW bits always hold it exactly.
  always_comb begin
    a_ext = PW'(din0);
    b_ext = PW'(din1);
    mult  = a_ext * b_ext;
  end

  // Product shift register; last is only meaningful on valid beats.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
      lst <= '0;
      for (int unsigned k = 0; k < NUM_STAGE; k++) prd[k] <= '0;
    end else if (ce) begin
      vld[0] <= in_valid;
      lst[0] <= in_valid & in_last;
      prd[0] <= mult;
      for (int unsigned k = 1; k < NUM_STAGE; k++) begin
        vld[k] <= vld[k-1];
        lst[k] <= lst[k-1];
        prd[k] <= prd[k-1];
      end
    end
  end

  assign p_valid = vld[NUM_STAGE-1];
  assign p_last  = lst[NUM_STAGE-1];
  assign product = prd[NUM_STAGE-1];

endmodule

// File: rtl/cnn_core_mac_pipe.sv
// Pipelined signed multiply-accumulate: streams operand pairs, emits one
// group sum per in_last. Define CNN_CORE_MAC_SAT_EN to saturate the
// accumulator on overflow and report it on out_ovf; otherwise the sum wraps.
module cnn_core_mac_pipe
  import cnn_core_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 6,
  parameter int NUM_STAGE  = 1,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACC_WIDTH-1:0]  dout,
  output logic                         out_ovf
);

  localparam int PW = prod_w(DIN0_WIDTH, DIN1_WIDTH);

  if (ACC_WIDTH < PW) begin : g_acc_width_check
    $error("ACC_WIDTH must be >= DIN0_WIDTH+DIN1_WIDTH");
  end
  if (ACC_WIDTH >= SAT_W) begin : g_acc_width_max_check
    $error("ACC_WIDTH too large for saturation helpers");
  end
  if (NUM_STAGE < 1 || NUM_STAGE > 4) begin : g_stage_check
    $error("NUM_STAGE must be in 1..4");
  end
  if (DIN0_WIDTH < 2 || DIN1_WIDTH < 2) begin : g_din_check
    $error("operand widths must be >= 2");
  end

  logic                        ce;
  logic                        p_valid;
  logic                        p_last;
  logic signed [PW-1:0]        product;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] ext;
  logic signed [ACC_WIDTH-1:0] sum;

  // A pending sum that downstream refuses freezes the whole pipeline.
  assign ce       = !out_valid | out_ready;
  assign in_ready = ce;

  cnn_core_mac_mul_pipe #(
    .DIN0_WIDTH (DIN0_WIDTH),
    .DIN1_WIDTH (DIN1_WIDTH),
    .NUM_STAGE  (NUM_STAGE)
  ) u_mul_pipe (
    .clk      (ap_clk),
    .rst_n    (ap_rst_n),
    .ce       (ce),
    .in_valid (in_valid),
    .in_last  (in_last),
    .din0     (din0),
    .din1     (din1),
    .p_valid  (p_valid),
    .p_last   (p_last),
    .product  (product)
  );

`ifdef CNN_CORE_MAC_SAT_EN
  logic [SAT_W:0] sat_res;
  logic           ovf_now;
  logic           ovf_sticky;
  logic           sat_unused;

  // Clamped accumulate; the add is done wide so overflow is visible.
  always_comb begin
    ext        = ACC_WIDTH'(product);
    sat_res    = sat_add(SAT_W'(acc), SAT_W'(ext), ACC_WIDTH);
    ovf_now    = sat_res[SAT_W];
    sum        = sat_res[ACC_WIDTH-1:0];
    sat_unused = ^sat_res[SAT_W-1:ACC_WIDTH];
  end
`else
  // Plain two's-complement accumulate.
  always_comb begin
    ext = ACC_WIDTH'(product);
    sum = acc + ext;
  end

  assign out_ovf = 1'b0;
`endif

  // Accumulator and output register; a last beat may refill out_valid
  // in the same cycle the previous sum is handed off.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      acc       <= '0;
      dout      <= '0;
      out_valid <= 1'b0;
`ifdef CNN_CORE_MAC_SAT_EN
      ovf_sticky <= 1'b0;
      out_ovf    <= 1'b0;
`endif
    end else if (ce) begin
      out_valid <= 1'b0;
      if (p_valid) begin
        if (p_last) begin
          dout      <= sum;
          out_valid <= 1'b1;
          acc       <= '0;
`ifdef CNN_CORE_MAC_SAT_EN
          out_ovf    <= ovf_sticky | ovf_now;
          ovf_sticky <= 1'b0;
`endif
        end else begin
          acc <= sum;
`ifdef CNN_CORE_MAC_SAT_EN
          ovf_sticky <= ovf_sticky | ovf_now;
`endif
        end
      end
    end
  end

endmodule
